usb_boot_ctrl: RTL and testbench

Sequences the exit from the USB bootloader into a user image on iCE40 boards. On a boot request it detaches from USB by dropping the D+ pull-up and inhibiting TX, waits for the host to see the disconnect, then presents the image select to SB_WARMBOOT and fires BOOT. It sits in the board top-level between tinyfpga_bootloader (boot, usb_tx_en) and the pin_pu / SB_WARMBOOT primitives.

---
 rtl/usb_boot_ctrl_pkg.sv | 14 +
 rtl/usb_boot_ctrl_counter.sv | 30 +++
 rtl/usb_boot_ctrl.sv | 147 ++++++++++++++
 tb/tb_usb_boot_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/usb_boot_ctrl_pkg.sv
// Shared state encoding and warmboot image constants for the USB boot-exit sequencer.
package usb_boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DETACH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_BOOT   = 3'd3
  } state_t;

  localparam logic [1:0] IMG_BOOTLOADER = 2'b00;
  localparam logic [1:0] IMG_USER       = 2'b01;

endpackage

// File: rtl/usb_boot_ctrl_counter.sv
// boot_dn_counter: loadable down-counter that saturates at zero; load has priority over decrement.
module boot_dn_counter #(
  parameter int              CNT_W   = 28,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/usb_boot_ctrl.sv
// USB detach -> SB_WARMBOOT sequencer. Optional idle auto-boot is enabled by defining
// USB_BOOT_CTRL_TIMEOUT_EN.
module usb_boot_ctrl
  import usb_boot_ctrl_pkg::*;
#(
  parameter int         DETACH_CYCLES  = 480000,
  parameter int         SETUP_CYCLES   = 8,
  parameter int         TIMEOUT_CYCLES = 240000000,
  parameter logic [1:0] DEFAULT_IMAGE  = IMG_USER,
  parameter int         CNT_W          = 28
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  input  logic       usb_activity,
  input  logic       usb_tx_en_in,
  output logic       usb_tx_en_out,
  output logic       usb_pu,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       wb_boot,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] DETACH_LD = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_image;
  logic             r_pu;
  logic             r_tx_gate;
  logic             r_s1;
  logic             r_s0;
  logic             r_boot;
  logic             r_busy;

  logic             w_ph_load;
  logic [CNT_W-1:0] w_ph_load_val;
  logic             w_ph_dec;
  logic [CNT_W-1:0] w_ph_count;
  logic             w_ph_zero;
  logic             w_idle_expire;
  logic             w_start;
  logic [1:0]       w_img_sel;

  // The phase counter is shared by DETACH and SETUP; it is reloaded on every phase entry.
  assign w_ph_load     = ((r_state == ST_IDLE) && w_start) ||
                         ((r_state == ST_DETACH) && w_ph_zero);
  assign w_ph_load_val = (r_state == ST_IDLE) ? DETACH_LD : SETUP_LD;
  assign w_ph_dec      = (r_state == ST_DETACH) || (r_state == ST_SETUP);

  boot_dn_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL ('0)
  ) u_phase_cnt (
    .clk        (clk_48mhz),
    .reset      (reset),
    .i_load     (w_ph_load),
    .i_load_val (w_ph_load_val),
    .i_dec      (w_ph_dec),
    .o_count    (w_ph_count),
    .o_zero     (w_ph_zero)
  );

`ifdef USB_BOOT_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] w_idle_count;
  logic             w_idle_zero;
  logic             w_idle_load;

  // Kept loaded outside IDLE so a later return to IDLE starts a full timeout window.
  assign w_idle_load = usb_activity || (r_state != ST_IDLE);

  boot_dn_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (TIMEOUT_LD)
  ) u_idle_cnt (
    .clk        (clk_48mhz),
    .reset      (reset),
    .i_load     (w_idle_load),
    .i_load_val (TIMEOUT_LD),
    .i_dec      (r_state == ST_IDLE),
    .o_count    (w_idle_count),
    .o_zero     (w_idle_zero)
  );

  assign w_idle_expire = (r_state == ST_IDLE) && w_idle_zero && !usb_activity;
`else
  assign w_idle_expire = 1'b0;
`endif

  assign w_start   = boot_req || w_idle_expire;
  assign w_img_sel = boot_req ? boot_image : DEFAULT_IMAGE;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_image   <= IMG_BOOTLOADER;
      r_pu      <= 1'b1;
      r_tx_gate <= 1'b1;
      r_s1      <= 1'b0;
      r_s0      <= 1'b0;
      r_boot    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_DETACH;
            r_image   <= w_img_sel;
            r_pu      <= 1'b0;
            r_tx_gate <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        ST_DETACH: begin
          if (w_ph_zero) begin
            r_state <= ST_SETUP;
            r_s1    <= r_image[1];
            r_s0    <= r_image[0];
          end
        end
        ST_SETUP: begin
          if (w_ph_zero) begin
            r_state <= ST_BOOT;
            r_boot  <= 1'b1;
          end
        end
        default: begin
          // BOOT is terminal: the fabric is about to reconfigure.
        end
      endcase
    end
  end

  assign usb_tx_en_out = r_tx_gate & usb_tx_en_in;
  assign usb_pu        = r_pu;
  assign wb_s1         = r_s1;
  assign wb_s0         = r_s0;
  assign wb_boot       = r_boot;
  assign busy          = r_busy;
  assign state         = r_state;

endmodule

// File: tb/tb_usb_boot_ctrl.sv
// Directed bench for usb_boot_ctrl with DETACH=5, SETUP=2, TIMEOUT=20.
module tb_usb_boot_ctrl;

  logic       clk_48mhz = 1'b0;
  logic       reset = 1'b1;
  logic       boot_req = 1'b0;
  logic [1:0] boot_image = 2'b00;
  logic       usb_activity = 1'b0;
  logic       usb_tx_en_in = 1'b1;
  logic       usb_tx_en_out;
  logic       usb_pu;
  logic       wb_s1;
  logic       wb_s0;
  logic       wb_boot;
  logic       busy;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  usb_boot_ctrl #(
    .DETACH_CYCLES  (5),
    .SETUP_CYCLES   (2),
    .TIMEOUT_CYCLES (20),
    .DEFAULT_IMAGE  (2'b01),
    .CNT_W          (28)
  ) dut (
    .clk_48mhz     (clk_48mhz),
    .reset         (reset),
    .boot_req      (boot_req),
    .boot_image    (boot_image),
    .usb_activity  (usb_activity),
    .usb_tx_en_in  (usb_tx_en_in),
    .usb_tx_en_out (usb_tx_en_out),
    .usb_pu        (usb_pu),
    .wb_s1         (wb_s1),
    .wb_s0         (wb_s0),
    .wb_boot       (wb_boot),
    .busy          (busy),
    .state         (state)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_pu"}, usb_pu, 1);
    chk({tag, "_sx"}, {wb_s1, wb_s0}, 0);
    chk({tag, "_boot"}, wb_boot, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx"}, usb_tx_en_out, usb_tx_en_in);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    boot_req = 1'b0;
    usb_activity = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_idle("rst");
  endtask

  // Entered just after the edge that moved the FSM to DETACH (cycle 1); checks through cycle 10.
  task automatic follow_boot(input string tag, input logic [1:0] img, input bit inject);
    logic [2:0] es;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      if (inject && c == 3) begin
        boot_req = 1'b1;
        boot_image = 2'b11;
      end else begin
        boot_req = 1'b0;
      end
      es = (c <= 5) ? 3'd1 : (c <= 7) ? 3'd2 : 3'd3;
      chk({tag, "_state"}, state, es);
      chk({tag, "_pu"}, usb_pu, 0);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_tx"}, usb_tx_en_out, 0);
      chk({tag, "_sx"}, {wb_s1, wb_s0}, (c >= 6) ? img : 2'b00);
      chk({tag, "_boot"}, wb_boot, (c >= 8) ? 1 : 0);
    end
  endtask

  task automatic run_boot(input string tag, input logic [1:0] img, input bit inject);
    boot_req = 1'b1;
    boot_image = img;
    chk({tag, "_tx_idle"}, usb_tx_en_out, 1);
    step();
    boot_req = 1'b0;
    boot_image = 2'b00;
    follow_boot(tag, img, inject);
  endtask

  initial begin
    do_reset();

    usb_tx_en_in = 1'b0;
    #1;
    chk("tx_follow_lo", usb_tx_en_out, 0);
    usb_tx_en_in = 1'b1;
    #1;
    chk("tx_follow_hi", usb_tx_en_out, 1);

    run_boot("basic", 2'b10, 1'b0);

    do_reset();
    run_boot("ignore", 2'b10, 1'b1);

    // Reset while in SETUP, then a fresh boot completes normally.
    do_reset();
    boot_req = 1'b1;
    boot_image = 2'b10;
    step();
    boot_req = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    chk("mid_in_setup", state, 2);
    reset = 1'b1;
    step();
    check_idle("mid_rst");
    reset = 1'b0;
    run_boot("after_rst", 2'b01, 1'b0);

`ifdef USB_BOOT_CTRL_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < 19; i++) begin
      step();
      chk("to_wait", state, 0);
    end
    step();
    follow_boot("to_boot", 2'b01, 1'b0);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      usb_activity = ((i % 15) == 14);
      step();
      chk("act_idle", state, 0);
    end
    usb_activity = 1'b0;

    do_reset();
    for (int i = 0; i < 19; i++) step();
    usb_activity = 1'b1;
    step();
    usb_activity = 1'b0;
    chk("act_on_expiry", state, 0);
    for (int i = 0; i < 19; i++) begin
      step();
      chk("reload_idle", state, 0);
    end

    do_reset();
    for (int i = 0; i < 19; i++) step();
    boot_req = 1'b1;
    boot_image = 2'b11;
    step();
    boot_req = 1'b0;
    follow_boot("collide", 2'b11, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
